// File: rtl/alu_cmd_issuer_if.sv
// Command / ALU / response bundle for alu_cmd_issuer.
// master = issuer side, slave = pipeline and ALU side.
interface alu_cmd_issuer_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [OPW-1:0]   cmd_op;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_opcode;
  logic             alu_en;
  logic [WIDTH-1:0] alu_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [OPW-1:0]   rsp_op;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op,
    input  alu_result, rsp_ready,
    output cmd_ready,
    output alu_a, alu_b, alu_opcode, alu_en,
    output rsp_valid, rsp_data, rsp_op
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op,
    output alu_result, rsp_ready,
    input  cmd_ready,
    input  alu_a, alu_b, alu_opcode, alu_en,
    input  rsp_valid, rsp_data, rsp_op
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Issues one ALU op at a time, waits ALU_LAT, queues results in order.
// Optional result checker: define ALU_CMD_ISSUER_CHECK_EN.
module alu_cmd_issuer #(
  parameter int WIDTH     = 16,
  parameter int OPW       = 3,
  parameter int ALU_LAT   = 0,
  parameter int OUT_DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  alu_cmd_issuer_if.master bus,
  output logic busy
`ifdef ALU_CMD_ISSUER_CHECK_EN
  ,
  output logic chk_err,
  output logic chk_err_sticky
`endif
);
  localparam int PW =
    (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [OPW-1:0]   op;
  } rsp_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       lat_cnt;
  logic [2:0]       lat_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [OPW-1:0]   op_q;

  rsp_t             mem [OUT_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic accept;
  logic push;
  logic pop;
  logic rsp_valid;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(OUT_DEPTH - 1)) ?
      '0 : p + 1'b1;
  endfunction

  assign bus.cmd_ready = rst_n &&
    (state == IDLE) &&
    (count < CW'(OUT_DEPTH));
  assign accept = bus.cmd_valid && bus.cmd_ready;

  assign rsp_valid = (count != '0);
  assign pop = rsp_valid && bus.rsp_ready;

  assign busy           = (state != IDLE);
  assign bus.alu_en     = (state == ISSUE);
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_opcode = op_q;

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  =
    rsp_valid ? mem[rd_ptr].data : '0;
  assign bus.rsp_op    =
    rsp_valid ? mem[rd_ptr].op : '0;

  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    push      = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (ALU_LAT == 0) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end else begin
          lat_nxt   = 3'(ALU_LAT - 1);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == '0) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end else begin
          lat_nxt = lat_cnt - 3'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand registers only load on accept, so the ALU
  // inputs hold steady through ISSUE and WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lat_cnt <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_nxt;
      if (accept) begin
        a_q  <= bus.cmd_a;
        b_q  <= bus.cmd_b;
        op_q <= bus.cmd_op;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{
        data: bus.alu_result,
        op:   op_q
      };
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef ALU_CMD_ISSUER_CHECK_EN
  logic [WIDTH-1:0] expected;

  always_comb begin
    expected = '0;
    unique case (1'b1)
      (op_q == OPW'(0)): expected = a_q + b_q;
      (op_q == OPW'(1)): expected = a_q - b_q;
      default:           expected = '0;
    endcase
  end

  assign chk_err = push &&
    (bus.alu_result != expected);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_err_sticky <= 1'b0;
    else if (chk_err) chk_err_sticky <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench: ALU_LAT=0 and ALU_LAT=3 issuers
// against behavioural ALUs with hand-computed results.
module tb_alu_cmd_issuer;
  localparam int W = 16;
  localparam int O = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  alu_cmd_issuer_if #(.WIDTH(W), .OPW(O)) b0 ();
  alu_cmd_issuer_if #(.WIDTH(W), .OPW(O)) b3 ();

  logic busy0;
  logic busy3;
`ifdef ALU_CMD_ISSUER_CHECK_EN
  logic ce0, cs0, ce3, cs3;
`endif

  alu_cmd_issuer #(
    .WIDTH(W), .OPW(O), .ALU_LAT(0), .OUT_DEPTH(2)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.master),
    .busy(busy0)
`ifdef ALU_CMD_ISSUER_CHECK_EN
    , .chk_err(ce0), .chk_err_sticky(cs0)
`endif
  );

  alu_cmd_issuer #(
    .WIDTH(W), .OPW(O), .ALU_LAT(3), .OUT_DEPTH(2)
  ) u3 (
    .clk(clk), .rst_n(rst_n), .bus(b3.master),
    .busy(busy3)
`ifdef ALU_CMD_ISSUER_CHECK_EN
    , .chk_err(ce3), .chk_err_sticky(cs3)
`endif
  );

  function automatic logic [W-1:0] alu_f(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [O-1:0] op
  );
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      default: return '0;
    endcase
  endfunction

  // Combinational ALU with an injectable 1+1 fault
  logic fault = 1'b0;
  assign b0.alu_result =
    (fault && b0.alu_opcode == 3'd0 &&
     b0.alu_a == 16'd1 && b0.alu_b == 16'd1) ?
    16'h1234 :
    alu_f(b0.alu_a, b0.alu_b, b0.alu_opcode);

  // Three-cycle ALU: result valid only 3 cycles after en
  logic [W-1:0] d1, d2, d3;
  logic v1 = 0, v2 = 0, v3 = 0;
  always @(posedge clk) begin
    d1 <= alu_f(b3.alu_a, b3.alu_b, b3.alu_opcode);
    d2 <= d1;
    d3 <= d2;
    v1 <= b3.alu_en;
    v2 <= v1;
    v3 <= v2;
  end
  assign b3.alu_result = v3 ? d3 : 16'hDEAD;

  logic [W-1:0] va [5] = '{16'h0003, 16'h0000,
    16'h8000, 16'h0005, 16'h0007};
  logic [W-1:0] vb [5] = '{16'h0005, 16'h0001,
    16'h8000, 16'h0003, 16'h0007};
  logic [O-1:0] vo [5] = '{3'd0, 3'd1,
    3'd0, 3'd1, 3'd5};
  logic [W-1:0] ve [5] = '{16'h0008, 16'hFFFF,
    16'h0000, 16'h0002, 16'h0000};

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({b0.cmd_ready, b0.alu_en, b0.rsp_valid, busy0,
         b0.alu_a, b0.alu_b, b0.alu_opcode,
         b0.rsp_data, b0.rsp_op} !== 58'h0) begin
      n_err++;
      $display("FAIL reset_outs_lat0 got nonzero");
    end
    n_cmp++;
    if ({b3.cmd_ready, b3.alu_en, b3.rsp_valid, busy3,
         b3.alu_a, b3.alu_b, b3.alu_opcode,
         b3.rsp_data, b3.rsp_op} !== 58'h0) begin
      n_err++;
      $display("FAIL reset_outs_lat3 got nonzero");
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (b0.cmd_ready !== 1'b1 || b3.cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready got %b%b want 11",
        b0.cmd_ready, b3.cmd_ready);
    end
  endtask

  task automatic test_add_sub;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (b0.cmd_ready !== 1'b1) begin
        n_err++;
        $display("FAIL addsub_ready[%0d] got %b want 1",
          i, b0.cmd_ready);
      end
      b0.cmd_valid = 1'b1;
      b0.cmd_a = va[i];
      b0.cmd_b = vb[i];
      b0.cmd_op = vo[i];
      @(negedge clk);
      b0.cmd_valid = 1'b0;
      n_cmp++;
      if ({b0.alu_en, b0.alu_a, b0.alu_b,
           b0.alu_opcode, b0.rsp_valid} !==
          {1'b1, va[i], vb[i], vo[i], 1'b0}) begin
        n_err++;
        $display("FAIL addsub_issue[%0d] en=%b a=%h b=%h op=%0d rv=%b want en=1 a=%h b=%h op=%0d rv=0",
          i, b0.alu_en, b0.alu_a, b0.alu_b,
          b0.alu_opcode, b0.rsp_valid,
          va[i], vb[i], vo[i]);
      end
      @(negedge clk);
      n_cmp++;
      if ({b0.rsp_valid, b0.rsp_data, b0.rsp_op,
           b0.alu_en, b0.alu_a} !==
          {1'b1, ve[i], vo[i], 1'b0, va[i]}) begin
        n_err++;
        $display("FAIL addsub_rsp[%0d] rv=%b d=%h op=%0d en=%b a=%h want rv=1 d=%h op=%0d en=0 a=%h",
          i, b0.rsp_valid, b0.rsp_data, b0.rsp_op,
          b0.alu_en, b0.alu_a, ve[i], vo[i], va[i]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (b0.rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL addsub_drained rv=%b want 0",
        b0.rsp_valid);
    end
  endtask

  task automatic test_back_to_back;
    b0.cmd_valid = 1'b1;
    b0.cmd_a = 16'h1111;
    b0.cmd_b = 16'h2222;
    b0.cmd_op = 3'd0;
    @(negedge clk);
    n_cmp++;
    if (b0.alu_en !== 1'b1 || b0.alu_a !== 16'h1111) begin
      n_err++;
      $display("FAIL b2b_issue1 en=%b a=%h want 1 1111",
        b0.alu_en, b0.alu_a);
    end
    b0.cmd_a = 16'h0010;
    b0.cmd_b = 16'h0020;
    b0.cmd_op = 3'd1;
    @(negedge clk);
    n_cmp++;
    if ({b0.cmd_ready, b0.rsp_valid, b0.rsp_data,
         b0.alu_a} !==
        {1'b1, 1'b1, 16'h3333, 16'h1111}) begin
      n_err++;
      $display("FAIL b2b_rsp1 rdy=%b rv=%b d=%h a=%h want 1 1 3333 1111",
        b0.cmd_ready, b0.rsp_valid, b0.rsp_data,
        b0.alu_a);
    end
    @(negedge clk);
    b0.cmd_valid = 1'b0;
    n_cmp++;
    if ({b0.alu_en, b0.alu_a, b0.alu_opcode} !==
        {1'b1, 16'h0010, 3'd1}) begin
      n_err++;
      $display("FAIL b2b_issue2 en=%b a=%h op=%0d want 1 0010 1",
        b0.alu_en, b0.alu_a, b0.alu_opcode);
    end
    @(negedge clk);
    n_cmp++;
    if (b0.rsp_valid !== 1'b1 ||
        b0.rsp_data !== 16'hFFF0) begin
      n_err++;
      $display("FAIL b2b_rsp2 rv=%b d=%h want 1 fff0",
        b0.rsp_valid, b0.rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    b0.rsp_ready = 1'b0;
    b0.cmd_valid = 1'b1;
    b0.cmd_a = 16'd1;
    b0.cmd_b = 16'd1;
    b0.cmd_op = 3'd0;
    @(negedge clk);
    b0.cmd_a = 16'd10;
    b0.cmd_b = 16'd4;
    b0.cmd_op = 3'd1;
    @(negedge clk);
    n_cmp++;
    if (b0.cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_ready_one_used got %b want 1",
        b0.cmd_ready);
    end
    @(negedge clk);
    b0.cmd_a = 16'd100;
    b0.cmd_b = 16'd200;
    b0.cmd_op = 3'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({b0.cmd_ready, b0.rsp_valid, b0.rsp_data,
           b0.rsp_op, busy0} !==
          {1'b0, 1'b1, 16'd2, 3'd0, 1'b0}) begin
        n_err++;
        $display("FAIL bp_full[%0d] rdy=%b rv=%b d=%h op=%0d busy=%b want 0 1 0002 0 0",
          k, b0.cmd_ready, b0.rsp_valid, b0.rsp_data,
          b0.rsp_op, busy0);
      end
    end
    b0.rsp_ready = 1'b1;
    @(negedge clk);
    b0.rsp_ready = 1'b0;
    n_cmp++;
    if ({b0.cmd_ready, b0.rsp_data, b0.rsp_op} !==
        {1'b1, 16'd6, 3'd1}) begin
      n_err++;
      $display("FAIL bp_pop1 rdy=%b d=%h op=%0d want 1 0006 1",
        b0.cmd_ready, b0.rsp_data, b0.rsp_op);
    end
    @(negedge clk);
    b0.cmd_valid = 1'b0;
    n_cmp++;
    if (b0.alu_en !== 1'b1 || b0.alu_a !== 16'd100) begin
      n_err++;
      $display("FAIL bp_issue3 en=%b a=%h want 1 0064",
        b0.alu_en, b0.alu_a);
    end
    @(negedge clk);
    n_cmp++;
    if (b0.cmd_ready !== 1'b0 || b0.rsp_data !== 16'd6) begin
      n_err++;
      $display("FAIL bp_full2 rdy=%b d=%h want 0 0006",
        b0.cmd_ready, b0.rsp_data);
    end
    b0.rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (b0.rsp_valid !== 1'b1 ||
        b0.rsp_data !== 16'd300) begin
      n_err++;
      $display("FAIL bp_order3 rv=%b d=%h want 1 012c",
        b0.rsp_valid, b0.rsp_data);
    end
    @(negedge clk);
    n_cmp++;
    if (b0.rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_empty rv=%b want 0",
        b0.rsp_valid);
    end
  endtask

  task automatic test_latency3;
    logic [W-1:0] la [2] = '{16'h1234, 16'h0005};
    logic [W-1:0] lb [2] = '{16'h0111, 16'h0007};
    logic [O-1:0] lo [2] = '{3'd0, 3'd1};
    logic [W-1:0] le [2] = '{16'h1345, 16'hFFFE};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      b3.cmd_valid = 1'b1;
      b3.cmd_a = la[i];
      b3.cmd_b = lb[i];
      b3.cmd_op = lo[i];
      @(negedge clk);
      b3.cmd_valid = 1'b0;
      n_cmp++;
      if ({b3.alu_en, b3.alu_a, b3.alu_b} !==
          {1'b1, la[i], lb[i]}) begin
        n_err++;
        $display("FAIL lat3_issue[%0d] en=%b a=%h b=%h",
          i, b3.alu_en, b3.alu_a, b3.alu_b);
      end
      for (int k = 2; k <= 4; k++) begin
        @(negedge clk);
        n_cmp++;
        if ({b3.alu_en, b3.alu_a, b3.alu_b,
             b3.alu_opcode, busy3, b3.rsp_valid} !==
            {1'b0, la[i], lb[i], lo[i],
             1'b1, 1'b0}) begin
          n_err++;
          $display("FAIL lat3_wait[%0d] c%0d en=%b a=%h b=%h op=%0d busy=%b rv=%b",
            i, k, b3.alu_en, b3.alu_a, b3.alu_b,
            b3.alu_opcode, busy3, b3.rsp_valid);
        end
      end
      @(negedge clk);
      n_cmp++;
      if ({b3.rsp_valid, b3.rsp_data, b3.rsp_op,
           busy3} !==
          {1'b1, le[i], lo[i], 1'b0}) begin
        n_err++;
        $display("FAIL lat3_rsp[%0d] rv=%b d=%h op=%0d busy=%b want 1 %h %0d 0",
          i, b3.rsp_valid, b3.rsp_data, b3.rsp_op,
          busy3, le[i], lo[i]);
      end
    end
  endtask

  task automatic test_reset_mid_wait;
    @(negedge clk);
    b3.cmd_valid = 1'b1;
    b3.cmd_a = 16'd7;
    b3.cmd_b = 16'd8;
    b3.cmd_op = 3'd0;
    @(negedge clk);
    b3.cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({b3.cmd_ready, b3.alu_en, b3.rsp_valid, busy3,
         b3.alu_a, b3.alu_b, b3.alu_opcode,
         b3.rsp_data, b3.rsp_op} !== 58'h0) begin
      n_err++;
      $display("FAIL rstwait_outs busy=%b a=%h rdy=%b",
        busy3, b3.alu_a, b3.cmd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (b3.rsp_valid !== 1'b0 ||
          b3.cmd_ready !== 1'b1) begin
        n_err++;
        $display("FAIL rstwait_after[%0d] rv=%b rdy=%b want 0 1",
          k, b3.rsp_valid, b3.cmd_ready);
      end
    end
  endtask

`ifdef ALU_CMD_ISSUER_CHECK_EN
  task automatic test_checker;
    fault = 1'b1;
    @(negedge clk);
    b0.cmd_valid = 1'b1;
    b0.cmd_a = 16'd1;
    b0.cmd_b = 16'd1;
    b0.cmd_op = 3'd0;
    @(negedge clk);
    b0.cmd_valid = 1'b0;
    n_cmp++;
    if (ce0 !== 1'b1 || cs0 !== 1'b0) begin
      n_err++;
      $display("FAIL chk_pulse err=%b sticky=%b want 1 0",
        ce0, cs0);
    end
    @(negedge clk);
    fault = 1'b0;
    n_cmp++;
    if ({ce0, cs0, b0.rsp_data} !==
        {1'b0, 1'b1, 16'h1234}) begin
      n_err++;
      $display("FAIL chk_after err=%b sticky=%b d=%h want 0 1 1234",
        ce0, cs0, b0.rsp_data);
    end
    b0.cmd_valid = 1'b1;
    b0.cmd_a = 16'd2;
    b0.cmd_b = 16'd3;
    @(negedge clk);
    b0.cmd_valid = 1'b0;
    n_cmp++;
    if (ce0 !== 1'b0 || cs0 !== 1'b1) begin
      n_err++;
      $display("FAIL chk_good_hold err=%b sticky=%b want 0 1",
        ce0, cs0);
    end
    n_cmp++;
    if (cs3 !== 1'b0 || ce3 !== 1'b0) begin
      n_err++;
      $display("FAIL chk_lat3_clean err=%b sticky=%b want 0 0",
        ce3, cs3);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if (cs0 !== 1'b0) begin
      n_err++;
      $display("FAIL chk_reset sticky=%b want 0", cs0);
    end
    @(negedge clk);
    b0.cmd_valid = 1'b1;
    @(negedge clk);
    b0.cmd_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ce0 !== 1'b0 || cs0 !== 1'b0) begin
      n_err++;
      $display("FAIL chk_clean err=%b sticky=%b want 0 0",
        ce0, cs0);
    end
  endtask
`endif

  initial begin
    b0.cmd_valid = 1'b0;
    b0.cmd_a = '0;
    b0.cmd_b = '0;
    b0.cmd_op = '0;
    b0.rsp_ready = 1'b1;
    b3.cmd_valid = 1'b0;
    b3.cmd_a = '0;
    b3.cmd_b = '0;
    b3.cmd_op = '0;
    b3.rsp_ready = 1'b1;
    test_reset();
    test_add_sub();
    test_back_to_back();
    test_backpressure();
    test_latency3();
    test_reset_mid_wait();
`ifdef ALU_CMD_ISSUER_CHECK_EN
    test_checker();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
